// File: rtl/layer_param_bank.sv
// Double-buffered per-layer configuration store: host writes fill a shadow bank,
// a commit copies shadow to active one layer per cycle once the datapath is idle.
module layer_param_bank #(
  parameter  int NUM_LAYERS         = 4,
  parameter  int ACT_TYPE_SIZE      = 4,
  parameter  int DENSE_TYPE_SIZE    = 4,
  parameter  int COST_TYPE_SIZE     = 8,
  parameter  int LEARNING_RATE_SIZE = 16,
  localparam int LIDX_W             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [LIDX_W-1:0]             wr_layer,
  input  logic [1:0]                    wr_field,
  input  logic [LEARNING_RATE_SIZE-1:0] wr_data,
  input  logic                          commit_req,
  output logic                          commit_ack,
  input  logic                          dp_busy,
  output logic                          pending,
  input  logic [LIDX_W-1:0]             rd_layer,
  output logic [ACT_TYPE_SIZE-1:0]      out_act_type,
  output logic [DENSE_TYPE_SIZE-1:0]    out_dense_type,
  output logic [COST_TYPE_SIZE-1:0]     out_cost_type,
  output logic [LEARNING_RATE_SIZE-1:0] out_learning_rate
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;

  localparam logic [LIDX_W:0]   NL   = (LIDX_W + 1)'(NUM_LAYERS);
  localparam logic [LIDX_W-1:0] LAST = LIDX_W'(NUM_LAYERS - 1);

  localparam logic [1:0] F_ACT   = 2'd0;
  localparam logic [1:0] F_DENSE = 2'd1;
  localparam logic [1:0] F_COST  = 2'd2;
  localparam logic [1:0] F_LR    = 2'd3;

  logic [1:0]        state;
  logic [LIDX_W-1:0] cnt;
  logic              ack_q;
  logic              pending_q;
  logic              wr_fire;
  logic              rd_hit;

  logic [ACT_TYPE_SIZE-1:0]      sh_act   [NUM_LAYERS];
  logic [DENSE_TYPE_SIZE-1:0]    sh_dense [NUM_LAYERS];
  logic [COST_TYPE_SIZE-1:0]     sh_cost  [NUM_LAYERS];
  logic [LEARNING_RATE_SIZE-1:0] sh_lr    [NUM_LAYERS];
  logic [ACT_TYPE_SIZE-1:0]      ac_act   [NUM_LAYERS];
  logic [DENSE_TYPE_SIZE-1:0]    ac_dense [NUM_LAYERS];
  logic [COST_TYPE_SIZE-1:0]     ac_cost  [NUM_LAYERS];
  logic [LEARNING_RATE_SIZE-1:0] ac_lr    [NUM_LAYERS];

  // Writes are only possible in IDLE, so the shadow is frozen for the whole commit.
  assign wr_ready   = rst_n && (state == ST_IDLE);
  assign wr_fire    = wr_valid && wr_ready && ({1'b0, wr_layer} < NL);
  assign rd_hit     = ({1'b0, rd_layer} < NL);
  assign commit_ack = ack_q;
  assign pending    = pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        sh_act[i]   <= '0;
        sh_dense[i] <= '0;
        sh_cost[i]  <= '0;
        sh_lr[i]    <= '0;
        ac_act[i]   <= '0;
        ac_dense[i] <= '0;
        ac_cost[i]  <= '0;
        ac_lr[i]    <= '0;
      end
    end else begin
      if (wr_fire) begin
        case (wr_field)
          F_ACT:   sh_act[wr_layer]   <= wr_data[ACT_TYPE_SIZE-1:0];
          F_DENSE: sh_dense[wr_layer] <= wr_data[DENSE_TYPE_SIZE-1:0];
          F_COST:  sh_cost[wr_layer]  <= wr_data[COST_TYPE_SIZE-1:0];
          F_LR:    sh_lr[wr_layer]    <= wr_data;
          default: ;
        endcase
      end
      if (state == ST_COPY) begin
        ac_act[cnt]   <= sh_act[cnt];
        ac_dense[cnt] <= sh_dense[cnt];
        ac_cost[cnt]  <= sh_cost[cnt];
        ac_lr[cnt]    <= sh_lr[cnt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (wr_fire) pending_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (commit_req) begin
            state <= dp_busy ? ST_WAIT : ST_COPY;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (!dp_busy) state <= ST_COPY;
        end
        ST_COPY: begin
          if (cnt == LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ack_q     <= 1'b1;
            pending_q <= 1'b0;
          end else begin
            cnt <= cnt + LIDX_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    out_act_type      = '0;
    out_dense_type    = '0;
    out_cost_type     = '0;
    out_learning_rate = '0;
    if (rd_hit) begin
      out_act_type      = ac_act[rd_layer];
      out_dense_type    = ac_dense[rd_layer];
      out_cost_type     = ac_cost[rd_layer];
      out_learning_rate = ac_lr[rd_layer];
    end
  end

endmodule

// File: tb/tb_layer_param_bank.sv
// Bench for layer_param_bank: a 4-layer instance is checked against a shadow/active
// model; a 3-layer instance sharing the inputs covers out-of-range layer indices.
module tb_layer_param_bank;

  localparam int NL = 4;

  typedef struct packed {
    int              lat;
    logic [3:0][3:0]  act;
    logic [3:0][3:0]  dense;
    logic [3:0][7:0]  cost;
    logic [3:0][15:0] lr;
  } exp_t;

  typedef struct {
    logic [1:0]  layer;
    logic [1:0]  field;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_layer = '0;
  logic [1:0]  wr_field = '0;
  logic [15:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        dp_busy = 1'b0;
  logic [1:0]  rd_layer = '0;

  logic        wr_ready, commit_ack, pending;
  logic [3:0]  out_act_type, out_dense_type;
  logic [7:0]  out_cost_type;
  logic [15:0] out_learning_rate;

  logic        wr_ready3, commit_ack3, pending3;
  logic [3:0]  act3, dense3;
  logic [7:0]  cost3;
  logic [15:0] lr3;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t m_sh, m_ac, zero_e;
  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  layer_param_bank #(.NUM_LAYERS(NL), .ACT_TYPE_SIZE(4), .DENSE_TYPE_SIZE(4),
                     .COST_TYPE_SIZE(8), .LEARNING_RATE_SIZE(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_layer(wr_layer), .wr_field(wr_field), .wr_data(wr_data),
    .commit_req(commit_req), .commit_ack(commit_ack), .dp_busy(dp_busy),
    .pending(pending), .rd_layer(rd_layer), .out_act_type(out_act_type),
    .out_dense_type(out_dense_type), .out_cost_type(out_cost_type),
    .out_learning_rate(out_learning_rate)
  );

  layer_param_bank #(.NUM_LAYERS(3), .ACT_TYPE_SIZE(4), .DENSE_TYPE_SIZE(4),
                     .COST_TYPE_SIZE(8), .LEARNING_RATE_SIZE(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready3),
    .wr_layer(wr_layer), .wr_field(wr_field), .wr_data(wr_data),
    .commit_req(commit_req), .commit_ack(commit_ack3), .dp_busy(dp_busy),
    .pending(pending3), .rd_layer(rd_layer), .out_act_type(act3),
    .out_dense_type(dense3), .out_cost_type(cost3), .out_learning_rate(lr3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input exp_t e, input string tag);
    for (int l = 0; l < NL; l++) begin
      rd_layer = 2'(l);
      #1;
      chk({tag, "_act"},   32'(out_act_type),      32'(e.act[l]));
      chk({tag, "_dense"}, 32'(out_dense_type),    32'(e.dense[l]));
      chk({tag, "_cost"},  32'(out_cost_type),     32'(e.cost[l]));
      chk({tag, "_lr"},    32'(out_learning_rate), 32'(e.lr[l]));
    end
  endtask

  task automatic model_write(input logic [1:0] l, input logic [1:0] f, input logic [15:0] d);
    case (f)
      2'd0: m_sh.act[l]   = d[3:0];
      2'd1: m_sh.dense[l] = d[3:0];
      2'd2: m_sh.cost[l]  = d[7:0];
      default: m_sh.lr[l] = d;
    endcase
  endtask

  task automatic do_write(input logic [1:0] l, input logic [1:0] f, input logic [15:0] d);
    wr_valid = 1'b1; wr_layer = l; wr_field = f; wr_data = d;
    tick();
    wr_valid = 1'b0;
    model_write(l, f, d);
  endtask

  // Expected copy result is captured from the model at the request edge.
  task automatic start_commit(input int lat);
    exp_t e;
    commit_req = 1'b1;
    e = m_sh;
    e.lat = lat;
    sb.push_back(e);
    tick();
    commit_req = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    exp_t e;
    int   cyc = 0;
    while (!commit_ack && cyc < 64) begin
      tick();
      cyc++;
    end
    e = sb.pop_front();
    if (!commit_ack) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
    else             chk({tag, "_ack_latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_pending_clear"}, 32'(pending), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check_reads(e, tag);
    m_ac = e;
    tick();
    chk({tag, "_ack_single"}, 32'(commit_ack), 32'd0);
  endtask

  initial begin
    zero_e = '0;
    m_sh   = '0;
    m_ac   = '0;
    vecs[0] = '{2'd1, 2'd2, 16'hABCD, 16'h00CD};
    vecs[1] = '{2'd0, 2'd1, 16'hFFF3, 16'h0003};
    vecs[2] = '{2'd3, 2'd0, 16'h00A7, 16'h0007};
    vecs[3] = '{2'd3, 2'd3, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{2'd0, 2'd2, 16'h0112, 16'h0012};
    vecs[5] = '{2'd1, 2'd3, 16'h8001, 16'h8001};
    vecs[6] = '{2'd2, 2'd1, 16'h002C, 16'h000C};
    vecs[7] = '{2'd3, 2'd2, 16'h7E5A, 16'h005A};

    // Reset state
    #2;
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ack", 32'(commit_ack), 32'd0);
    check_reads(zero_e, "rst");
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);
    chk("rel_pending", 32'(pending), 32'd0);
    tick();

    // Basic write and commit; dp_busy rises during COPY without aborting it
    do_write(2'd2, 2'd3, 16'h1234);
    do_write(2'd2, 2'd0, 16'h0005);
    chk("pend_after_wr", 32'(pending), 32'd1);
    check_reads(m_ac, "pre_commit");
    start_commit(NL);
    dp_busy = 1'b1;
    wait_ack("basic");
    dp_busy = 1'b0;
    rd_layer = 2'd2;
    #1;
    chk("basic_lr", 32'(out_learning_rate), 32'h1234);
    chk("basic_act", 32'(out_act_type), 32'h5);

    // Table-driven writes, checked after a commit
    foreach (vecs[i]) do_write(vecs[i].layer, vecs[i].field, vecs[i].data);
    check_reads(m_ac, "tbl_pre");
    start_commit(NL);
    wait_ack("tbl");
    foreach (vecs[i]) begin
      logic [15:0] got;
      rd_layer = vecs[i].layer;
      #1;
      case (vecs[i].field)
        2'd0: got = 16'(out_act_type);
        2'd1: got = 16'(out_dense_type);
        2'd2: got = 16'(out_cost_type);
        default: got = out_learning_rate;
      endcase
      chk($sformatf("tbl_vec%0d", i), 32'(got), 32'(vecs[i].exp));
    end
    tick();

    // Deferred commit while busy; extra request during WAIT is ignored
    do_write(2'd1, 2'd0, 16'h0009);
    dp_busy = 1'b1;
    start_commit(NL + 1);
    for (int i = 0; i < 10; i++) begin
      commit_req = (i == 3);
      tick();
      chk("wait_no_ack", 32'(commit_ack), 32'd0);
      chk("wait_wr_ready", 32'(wr_ready), 32'd0);
      chk("wait_pending", 32'(pending), 32'd1);
    end
    commit_req = 1'b0;
    dp_busy = 1'b0;
    wait_ack("busy");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_extra_ack", 32'(commit_ack), 32'd0);
    end

    // Out-of-range layer on the 3-layer instance: accepted, no state change
    chk("oor_pend3_before", 32'(pending3), 32'd0);
    do_write(2'd3, 2'd2, 16'hABCD);
    chk("oor_pend4", 32'(pending), 32'd1);
    chk("oor_pend3", 32'(pending3), 32'd0);
    start_commit(NL);
    wait_ack("oor");
    rd_layer = 2'd3;
    #1;
    chk("oor_cost4", 32'(out_cost_type), 32'hCD);
    chk("oor_rd3_act", 32'(act3), 32'd0);
    chk("oor_rd3_dense", 32'(dense3), 32'd0);
    chk("oor_rd3_cost", 32'(cost3), 32'd0);
    chk("oor_rd3_lr", 32'(lr3), 32'd0);
    tick();

    // Write on the same edge as commit_req is part of that commit
    wr_valid = 1'b1; wr_layer = 2'd0; wr_field = 2'd1; wr_data = 16'h0003;
    model_write(2'd0, 2'd1, 16'h0003);
    start_commit(NL);
    wr_valid = 1'b0;
    wait_ack("same_edge");
    rd_layer = 2'd0;
    #1;
    chk("same_edge_dense", 32'(out_dense_type), 32'h3);
    chk("same_edge_pending", 32'(pending), 32'd0);
    tick();

    // Reset during the second COPY cycle discards everything
    do_write(2'd1, 2'd3, 16'hBEEF);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    check_reads(zero_e, "mid_rst");
    tick();
    chk("mid_rst_ack", 32'(commit_ack), 32'd0);
    rst_n = 1'b1;
    m_sh = '0;
    m_ac = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_ack", 32'(commit_ack), 32'd0);
    end
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    check_reads(zero_e, "post_rst");

    // Empty commit still runs the full copy and acknowledges
    start_commit(NL);
    wait_ack("empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
